// File: rtl/ethernet2_type_encoder_pkg.sv
// Shared Ethernet bus types and constants for the transmit-side Ethernet II framer.
package EthernetBus;

    typedef logic [47:0] macaddr_t;
    typedef logic [11:0] vlan_t;
    typedef logic [15:0] ethertype_t;

    localparam ethertype_t ETHERTYPE_IPV4 = 16'h0800;
    localparam ethertype_t ETHERTYPE_ARP  = 16'h0806;
    localparam ethertype_t ETHERTYPE_IPV6 = 16'h86DD;
    localparam ethertype_t ETHERTYPE_VLAN = 16'h8100;

    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
        macaddr_t    dst_mac;
        ethertype_t  ethertype;
    } EthernetTxL2Bus;

    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
    } EthernetFramedTxBus;

    // One delay-line stage; keep marks words belonging to the accepted frame.
    typedef struct packed {
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
        logic        keep;
    } delay_word_t;

    typedef enum logic [1:0] {IDLE, HEADER, BODY, FLUSH} state_t;
    typedef enum logic [1:0] {TRACK_IDLE, TRACK_FRAME, DISCARD} track_t;

    function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [2:0] n);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (i < 32'(n)) m[31 - 8*i -: 8] = 8'hFF;
        return d & m;
    endfunction

endpackage

// File: rtl/ethernet2_type_encoder_if.sv
// Payload-side and framed-side bus interfaces of the Ethernet II framer.
interface ethernet_tx_l2_if;
    EthernetBus::EthernetTxL2Bus bus;
    modport master (output bus);
    modport slave  (input  bus);
endinterface

interface ethernet_framed_tx_if;
    EthernetBus::EthernetFramedTxBus bus;
    modport master (output bus);
    modport slave  (input  bus);
endinterface

// File: rtl/ethernet2_realigner.sv
// Delay line plus 2-byte payload realigner; produces the next body/flush/commit word.
module ethernet2_realigner
    import EthernetBus::*;
#(
    parameter int unsigned STAGES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  delay_word_t        in_word,
    input  ethertype_t         ethertype,
    output EthernetFramedTxBus body,
    output logic               flush_start,
    output logic               done
);

    delay_word_t line [STAGES];
    delay_word_t d;
    logic [15:0] resid, resid_n;
    logic [1:0]  rc, rc_n;
    logic        seen, seen_n;
    logic        pend, pend_n;
    logic [2:0]  bv;

    assign d = line[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) line[i] <= '0;
            resid <= '0;
            rc    <= '0;
            seen  <= 1'b0;
            pend  <= 1'b0;
        end else begin
            line[0] <= in_word;
            for (int unsigned i = 1; i < STAGES; i++) line[i] <= line[i-1];
            resid <= resid_n;
            rc    <= rc_n;
            seen  <= seen_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        body        = '0;
        flush_start = 1'b0;
        done        = 1'b0;
        resid_n     = resid;
        rc_n        = rc;
        seen_n      = seen;
        pend_n      = 1'b0;
        bv          = 3'd0;
        if (pend) begin
            body.commit = 1'b1;
            done        = 1'b1;
            rc_n        = '0;
            seen_n      = 1'b0;
        end else if (d.keep) begin
            if (d.drop) begin
                body.drop = 1'b1;
                done      = 1'b1;
                rc_n      = '0;
                seen_n    = 1'b0;
            end else if (d.commit) begin
                if (!seen) begin
                    body.data_valid  = 1'b1;
                    body.bytes_valid = 3'd2;
                    body.data        = {ethertype, 16'h0};
                    pend_n           = 1'b1;
                    flush_start      = 1'b1;
                end else if (rc != 2'd0) begin
                    body.data_valid  = 1'b1;
                    body.bytes_valid = {1'b0, rc};
                    body.data        = mask_bytes({resid, 16'h0}, {1'b0, rc});
                    pend_n           = 1'b1;
                    flush_start      = 1'b1;
                end else begin
                    body.commit = 1'b1;
                    done        = 1'b1;
                    seen_n      = 1'b0;
                end
            end else if (d.data_valid) begin
                bv               = (d.bytes_valid >= 3'd2) ? 3'd4 : 3'd2 + d.bytes_valid;
                body.data_valid  = 1'b1;
                body.bytes_valid = bv;
                body.data        = mask_bytes({seen ? resid : ethertype, d.data[31:16]}, bv);
                resid_n          = d.data[15:0];
                rc_n             = (d.bytes_valid > 3'd2) ? 2'(d.bytes_valid - 3'd2) : 2'd0;
                seen_n           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ethernet2_type_encoder.sv
// Transmit-side Ethernet II framer: header FSM, overflow tracking, registered output.
module ethernet2_type_encoder
    import EthernetBus::*;
#(
    parameter bit VLAN_TAG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    ethernet_tx_l2_if.slave   l2_bus,
    input  macaddr_t          our_mac,
    input  vlan_t             vlan_id,
    input  logic [2:0]        vlan_pri,
    ethernet_framed_tx_if.master tx_bus,
    output logic              overflow
);

    localparam int unsigned H = VLAN_TAG ? 4 : 3;

    state_t             state, state_n;
    track_t             track, track_n;
    logic [1:0]         hdr_idx, hdr_idx_n;
    macaddr_t           dst, src;
    ethertype_t         et;
    vlan_t              vid;
    logic [2:0]         pri;
    logic               accept;
    logic [31:0]        hdr_word;
    delay_word_t        in_word;
    EthernetFramedTxBus body, tx_n;
    logic               flush_start, done;

    assign accept = l2_bus.bus.start && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            track      <= TRACK_IDLE;
            hdr_idx    <= '0;
            dst        <= '0;
            src        <= '0;
            et         <= '0;
            vid        <= '0;
            pri        <= '0;
            tx_bus.bus <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            track      <= track_n;
            hdr_idx    <= hdr_idx_n;
            tx_bus.bus <= tx_n;
            overflow   <= l2_bus.bus.start && (state != IDLE);
            if (accept) begin
                dst <= l2_bus.bus.dst_mac;
                et  <= l2_bus.bus.ethertype;
                src <= our_mac;
                vid <= vlan_id;
                pri <= vlan_pri;
            end
        end
    end

    // Input-side tracker: decides which incoming words belong to the accepted frame.
    always_comb begin
        track_n = track;
        if (accept)                                      track_n = TRACK_FRAME;
        else if (l2_bus.bus.start)                       track_n = DISCARD;
        else if (l2_bus.bus.commit || l2_bus.bus.drop)   track_n = TRACK_IDLE;
        in_word = '0;
        if (track == TRACK_FRAME) begin
            in_word.data_valid  = l2_bus.bus.data_valid;
            in_word.bytes_valid = l2_bus.bus.bytes_valid;
            in_word.data        = l2_bus.bus.data;
            in_word.commit      = l2_bus.bus.commit;
            in_word.drop        = l2_bus.bus.drop;
            in_word.keep        = 1'b1;
        end
    end

    always_comb begin
        case (hdr_idx)
            2'd0:    hdr_word = dst[47:16];
            2'd1:    hdr_word = {dst[15:0], src[47:32]};
            2'd2:    hdr_word = src[31:0];
            default: hdr_word = {ETHERTYPE_VLAN, pri, 1'b0, vid};
        endcase
    end

    always_comb begin
        state_n   = state;
        hdr_idx_n = hdr_idx;
        tx_n      = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n    = HEADER;
                    hdr_idx_n  = '0;
                    tx_n.start = 1'b1;
                end
            end
            HEADER: begin
                tx_n.data_valid  = 1'b1;
                tx_n.bytes_valid = 3'd4;
                tx_n.data        = hdr_word;
                if (hdr_idx == 2'(H - 1)) state_n = BODY;
                else                      hdr_idx_n = hdr_idx + 2'd1;
            end
            BODY, FLUSH: begin
                tx_n = body;
                if (done)             state_n = IDLE;
                else if (flush_start) state_n = FLUSH;
            end
            default: state_n = IDLE;
        endcase
    end

    ethernet2_realigner #(.STAGES(H)) u_realigner (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_word     (in_word),
        .ethertype   (et),
        .body        (body),
        .flush_start (flush_start),
        .done        (done)
    );

endmodule

// File: tb/tb_ethernet2_type_encoder.sv
// Bench for the Ethernet II framer: byte-queue reference model for untagged and tagged instances.
module tb_ethernet2_type_encoder;
    import EthernetBus::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ethernet_tx_l2_if     l2 ();
    ethernet_framed_tx_if tx0 ();
    ethernet_framed_tx_if tx1 ();

    macaddr_t   our_mac  = 48'h020000000002;
    vlan_t      vlan_id  = 12'h123;
    logic [2:0] vlan_pri = 3'd5;
    logic       ovf0, ovf1;

    ethernet2_type_encoder #(.VLAN_TAG(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .l2_bus(l2), .our_mac(our_mac),
        .vlan_id(vlan_id), .vlan_pri(vlan_pri), .tx_bus(tx0), .overflow(ovf0));
    ethernet2_type_encoder #(.VLAN_TAG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .l2_bus(l2), .our_mac(our_mac),
        .vlan_id(vlan_id), .vlan_pri(vlan_pri), .tx_bus(tx1), .overflow(ovf1));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected outputs keyed by cycle*2 + instance (0 untagged, 1 tagged).
    EthernetFramedTxBus ex [int];
    bit                 ovx [int];
    int                 busy_end [2];
    int                 in_mode  [2];
    logic [7:0]         bq [2][$];
    EthernetFramedTxBus log0 [int];
    EthernetFramedTxBus log1 [int];
    bit                 olog0 [int];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    function automatic void put(input int k, input int n, input EthernetFramedTxBus w);
        int key;
        key = n*2 + k;
        if (ex.exists(key)) ex[key] = EthernetFramedTxBus'(ex[key] | w);
        else                ex[key] = w;
    endfunction

    function automatic EthernetFramedTxBus pop_word(input int k);
        EthernetFramedTxBus w;
        int cnt;
        w = '0;
        w.data_valid = 1'b1;
        cnt = 0;
        while (cnt < 4 && bq[k].size() > 0) begin
            w.data[31 - 8*cnt -: 8] = bq[k].pop_front();
            cnt++;
        end
        w.bytes_valid = 3'(cnt);
        return w;
    endfunction

    task automatic model_step(input int n);
        EthernetTxL2Bus     b;
        EthernetFramedTxBus w;
        logic [31:0]        hw [4];
        int                 h;
        b = l2.bus;
        for (int k = 0; k < 2; k++) begin
            h = 3 + k;
            if (b.start) begin
                if (n >= busy_end[k]) begin
                    busy_end[k] = 1 << 30;
                    in_mode[k]  = 1;
                    bq[k] = {};
                    bq[k].push_back(b.ethertype[15:8]);
                    bq[k].push_back(b.ethertype[7:0]);
                    w = '0; w.start = 1'b1; put(k, n+1, w);
                    hw[0] = b.dst_mac[47:16];
                    hw[1] = {b.dst_mac[15:0], our_mac[47:32]};
                    hw[2] = our_mac[31:0];
                    hw[3] = {16'h8100, vlan_pri, 1'b0, vlan_id};
                    for (int i = 0; i < h; i++) begin
                        w = '0; w.data_valid = 1'b1; w.bytes_valid = 3'd4; w.data = hw[i];
                        put(k, n+2+i, w);
                    end
                end else begin
                    ovx[(n+1)*2 + k] = 1'b1;
                    in_mode[k] = 2;
                end
            end else if (in_mode[k] == 1) begin
                if (b.data_valid) begin
                    for (int i = 0; i < int'(b.bytes_valid); i++) bq[k].push_back(b.data[31 - 8*i -: 8]);
                    put(k, n+h+1, pop_word(k));
                end else if (b.commit) begin
                    if (bq[k].size() > 0) begin
                        put(k, n+h+1, pop_word(k));
                        w = '0; w.commit = 1'b1; put(k, n+h+2, w);
                        busy_end[k] = n+h+2;
                    end else begin
                        w = '0; w.commit = 1'b1; put(k, n+h+1, w);
                        busy_end[k] = n+h+1;
                    end
                    in_mode[k] = 0;
                end else if (b.drop) begin
                    w = '0; w.drop = 1'b1; put(k, n+h+1, w);
                    busy_end[k] = n+h+1;
                    in_mode[k] = 0;
                end
            end else if (in_mode[k] == 2 && (b.commit || b.drop)) begin
                in_mode[k] = 0;
            end
        end
    endtask

    initial begin
        busy_end[0] = 0; busy_end[1] = 0;
        in_mode[0]  = 0; in_mode[1]  = 0;
    end

    always @(posedge clk) begin
        if (rst_n) model_step(cyc);
        cyc = cyc + 1;
    end

    // Reset discards everything still pending, including the current cycle.
    always @(negedge rst_n) begin : model_reset
        int dk [$];
        foreach (ex[key]) if (key >= cyc*2) dk.push_back(key);
        foreach (dk[i]) ex.delete(dk[i]);
        dk = {};
        foreach (ovx[key]) if (key >= cyc*2) dk.push_back(key);
        foreach (dk[i]) ovx.delete(dk[i]);
        for (int k = 0; k < 2; k++) begin
            busy_end[k] = 0;
            in_mode[k]  = 0;
            bq[k] = {};
        end
    end

    always @(negedge clk) begin : compare
        EthernetFramedTxBus e0, e1;
        bit o0, o1;
        e0 = ex.exists(cyc*2)     ? ex[cyc*2]     : '0;
        e1 = ex.exists(cyc*2 + 1) ? ex[cyc*2 + 1] : '0;
        o0 = ovx.exists(cyc*2)     ? ovx[cyc*2]     : 1'b0;
        o1 = ovx.exists(cyc*2 + 1) ? ovx[cyc*2 + 1] : 1'b0;
        log0[cyc]  = tx0.bus;
        log1[cyc]  = tx1.bus;
        olog0[cyc] = ovf0;
        chk("tx0", 64'(tx0.bus), 64'(e0));
        chk("tx1", 64'(tx1.bus), 64'(e1));
        chk("ovf0", 64'(ovf0), 64'(o0));
        chk("ovf1", 64'(ovf1), 64'(o1));
    end

    function automatic logic [31:0] pword(input int i, input logic [2:0] b);
        logic [31:0] d;
        d = {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
        return mask_bytes(d, b);
    endfunction

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            l2.bus = '0;
            rst_n  = 1'b1;
        end
    endtask

    task automatic send(input macaddr_t dst, input logic [15:0] et, input int nw,
                        input logic [2:0] last_b, input bit do_drop, input int gap_after,
                        input int rst_word, output int s, output int c);
        EthernetTxL2Bus w;
        @(posedge clk); #1;
        w = '0; w.start = 1'b1; w.dst_mac = dst; w.ethertype = et;
        l2.bus = w;
        s = cyc;
        for (int i = 0; i < nw; i++) begin
            @(posedge clk); #1;
            w = '0; w.data_valid = 1'b1;
            w.bytes_valid = (i == nw-1) ? last_b : 3'd4;
            w.data = pword(i, w.bytes_valid);
            l2.bus = w;
            rst_n = (i == rst_word) ? 1'b0 : 1'b1;
            if (i == gap_after) begin
                @(posedge clk); #1;
                l2.bus = '0;
                rst_n  = 1'b1;
            end
        end
        @(posedge clk); #1;
        w = '0;
        if (do_drop) w.drop = 1'b1; else w.commit = 1'b1;
        l2.bus = w;
        rst_n = 1'b1;
        c = cyc;
        @(posedge clk); #1;
        l2.bus = '0;
    endtask

    localparam macaddr_t DST = 48'h020000000001;

    initial begin
        int s, c, sum;
        l2.bus = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_tx0", 64'(tx0.bus), 64'd0);
        chk("reset_ovf0", 64'(ovf0), 64'd0);
        drive_idle(3);

        // Full 64-byte payload
        send(DST, 16'h0800, 16, 3'd4, 1'b0, -1, -1, s, c);
        drive_idle(10);
        chk("hdr0", 64'(log0[s+2].data), 64'h02000000);
        chk("hdr1", 64'(log0[s+3].data), 64'h00010200);
        chk("hdr2", 64'(log0[s+4].data), 64'h00000002);
        chk("body_first", 64'(log0[s+5].data), 64'h08000102);
        chk("flush_data", 64'(log0[c+4].data), 64'h3F400000);
        chk("flush_bv", 64'(log0[c+4].bytes_valid), 64'd2);
        chk("commit_c5", 64'(log0[c+5].commit), 64'd1);
        chk("vlan_hdr3", 64'(log1[s+5].data), 64'h8100A123);
        chk("vlan_commit_c6", 64'(log1[c+6].commit), 64'd1);
        sum = 0;
        for (int t = s+1; t <= c+5; t++) sum += int'(log0[t].bytes_valid);
        chk("total_bytes", 64'(sum), 64'd78);

        // Short 5-byte payload
        send(DST, 16'h0800, 2, 3'd1, 1'b0, -1, -1, s, c);
        drive_idle(10);
        chk("short_w0", 64'({log0[s+5].bytes_valid, log0[s+5].data}), {29'd0, 3'd4, 32'h08000102});
        chk("short_w1", 64'({log0[s+6].bytes_valid, log0[s+6].data}), {29'd0, 3'd3, 32'h03040500});
        chk("short_commit_c4", 64'(log0[c+4].commit), 64'd1);

        // Drop mid-payload with an input gap, then a normal frame
        send(DST, 16'h86DD, 3, 3'd4, 1'b1, 0, -1, s, c);
        drive_idle(10);
        chk("drop_d4", 64'(log0[c+4].drop), 64'd1);
        chk("drop_nocommit", 64'(log0[c+5].commit), 64'd0);
        send(48'h0A0B0C0D0E0F, 16'h0806, 4, 3'd3, 1'b0, -1, -1, s, c);
        drive_idle(10);

        // Overflow: second start while the first frame is still being emitted
        send(DST, 16'h0800, 4, 3'd4, 1'b0, -1, -1, s, c);
        send(48'hFFFFFFFFFFFF, 16'h0806, 2, 3'd4, 1'b0, -1, -1, s, sum);
        drive_idle(10);
        chk("ovf_pulse", 64'(olog0[s+1]), 64'd1);
        chk("ovf_once", 64'(olog0[s+2]), 64'd0);
        send(DST, 16'h0800, 3, 3'd2, 1'b0, -1, -1, s, c);
        drive_idle(10);

        // Empty frame
        send(DST, 16'h0800, 0, 3'd4, 1'b0, -1, -1, s, c);
        drive_idle(10);
        chk("empty_flush", 64'({log0[s+5].bytes_valid, log0[s+5].data}), {29'd0, 3'd2, 32'h08000000});
        chk("empty_commit", 64'(log0[s+6].commit), 64'd1);

        // Reset mid-body, then a normal frame
        send(DST, 16'h0800, 8, 3'd4, 1'b0, -1, 4, s, c);
        drive_idle(10);
        chk("rst_tx0", 64'(log0[s+5]), 64'd0);
        chk("rst_tx1", 64'(log1[s+5]), 64'd0);
        send(DST, 16'h0800, 5, 3'd4, 1'b0, -1, -1, s, c);
        drive_idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
